// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing generator: register map,
// default 640x480 timing and the active configuration bundle.
package vga_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        REG_XSCROLL = 2'd0,
        REG_YSCROLL = 2'd1,
        REG_BASE    = 2'd2,
        REG_CTRL    = 2'd3
    } cfg_reg_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        logic [COORD_W-1:0] xscroll;
        logic [COORD_W-1:0] yscroll;
        logic [COORD_W-1:0] base;
        logic               enable;
    } vga_cfg_t;

endpackage

// File: rtl/vga_shadow_regs.sv
// Pending/active configuration pair: writes land in pending and mark dirty,
// the apply strobe moves only the dirty entries into the active set.
module vga_shadow_regs
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [COORD_W-1:0] wr_data,
    input  logic               apply,
    output vga_cfg_t           active
);

    vga_cfg_t   pend;
    logic [3:0] dirty;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend   <= '0;
            active <= '0;
            dirty  <= '0;
        end else begin
            // Transfer sees the pre-write pending value; a coincident write
            // re-marks its dirty bit below and waits for the next boundary.
            if (apply) begin
                if (dirty[REG_XSCROLL]) active.xscroll <= pend.xscroll;
                if (dirty[REG_YSCROLL]) active.yscroll <= pend.yscroll;
                if (dirty[REG_BASE])    active.base    <= pend.base;
                if (dirty[REG_CTRL])    active.enable  <= pend.enable;
                dirty <= '0;
            end
            if (wr_en) begin
                case (cfg_reg_e'(wr_addr))
                    REG_XSCROLL: pend.xscroll <= wr_data;
                    REG_YSCROLL: pend.yscroll <= wr_data;
                    REG_BASE:    pend.base    <= wr_data;
                    REG_CTRL:    pend.enable  <= wr_data[0];
                    default:     pend         <= pend;
                endcase
                dirty[wr_addr] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing.sv
// Pixel-domain VGA timing generator: h/v counters, registered sync/blank,
// scrolled coordinates and frame-boundary application of CPU config writes.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sync,
    input  logic [1:0]         cfg_addr,
    input  logic [COORD_W-1:0] cfg_data,
    output logic               hsync,
    output logic               vsync,
    output logic               blank,
    output logic               frame_start,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] base
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] hcnt, vcnt;
    logic               h_last, v_last, apply;
    logic               hs_on, vs_on, visible;
    vga_cfg_t           cfg;

    assign h_last  = (hcnt == H_LAST);
    assign v_last  = (vcnt == V_LAST);
    assign apply   = h_last && v_last;
    assign hs_on   = (hcnt >= HS_START) && (hcnt < HS_END);
    assign vs_on   = (vcnt >= VS_START) && (vcnt < VS_END);
    assign visible = (hcnt < H_VIS) && (vcnt < V_VIS) && cfg.enable;

    vga_shadow_regs u_shadow (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (sync),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .apply   (apply),
        .active  (cfg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Outputs describe the counter position of the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
            base        <= '0;
        end else begin
            hsync       <= hs_on ? HS_POL : ~HS_POL;
            vsync       <= vs_on ? VS_POL : ~VS_POL;
            blank       <= ~visible;
            frame_start <= (hcnt == '0) && (vcnt == '0);
            x           <= hcnt + cfg.xscroll;
            y           <= vcnt + cfg.yscroll;
            base        <= cfg.base;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Randomized self-checking bench for vga_timing on a reduced raster, checked
// every cycle against a frame-position model of the timing and config rules.
module tb_vga_timing;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst, sync;
    logic [1:0] cfg_addr;
    logic [9:0] cfg_data;
    logic       hsync, vsync, blank, frame_start;
    logic [9:0] x, y, base;
    logic       p_hsync, p_vsync, p_blank, p_frame_start;
    logic [9:0] p_x, p_y, p_base;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    vga_timing #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
        .clk(clk), .rst(rst), .sync(sync), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .hsync(hsync), .vsync(vsync), .blank(blank), .frame_start(frame_start),
        .x(x), .y(y), .base(base));

    vga_timing #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                 .HS_POL(1'b1), .VS_POL(1'b1)) dut_pol (
        .clk(clk), .rst(rst), .sync(sync), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .hsync(p_hsync), .vsync(p_vsync), .blank(p_blank), .frame_start(p_frame_start),
        .x(p_x), .y(p_y), .base(p_base));

    // Model: linear position inside the frame plus pending/active config.
    int mpos = 0, shown = -1;
    int pend[4], act[4];
    bit dirty[4];
    bit e_in_hs, e_in_vs, e_blank, e_fs;
    int e_x, e_y, e_base;

    always @(posedge clk) begin
        int h, v;
        if (rst) begin
            mpos = 0; shown = -1;
            for (int i = 0; i < 4; i++) begin pend[i] = 0; act[i] = 0; dirty[i] = 0; end
            e_in_hs = 0; e_in_vs = 0; e_blank = 1; e_fs = 0; e_x = 0; e_y = 0; e_base = 0;
        end else begin
            h = mpos % HT;
            v = mpos / HT;
            e_in_hs = (h >= HA + HF) && (h < HA + HF + HS);
            e_in_vs = (v >= VA + VF) && (v < VA + VF + VS);
            e_blank = !(h < HA && v < VA && act[3] != 0);
            e_fs    = (mpos == 0);
            e_x     = (h + act[0]) % 1024;
            e_y     = (v + act[1]) % 1024;
            e_base  = act[2];
            shown   = mpos;
            if (mpos == FRAME - 1)
                for (int i = 0; i < 4; i++) begin
                    if (dirty[i]) act[i] = pend[i];
                    dirty[i] = 0;
                end
            if (sync) begin
                pend[cfg_addr]  = (cfg_addr == 2'd3) ? int'(cfg_data[0]) : int'(cfg_data);
                dirty[cfg_addr] = 1;
            end
            mpos = (mpos + 1) % FRAME;
        end
    end

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s at t=%0t pos=%0d: got %0h expected %0h", name, $time, shown, act_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("outputs", {hsync, vsync, blank, frame_start, x, y, base},
                {!e_in_hs, !e_in_vs, e_blank, e_fs, 10'(e_x), 10'(e_y), 10'(e_base)});
            chk("pol_sync", {p_hsync, p_vsync}, {e_in_hs, e_in_vs});
        end
    end

    task automatic wait_mpos(input int p);
        int n = 0;
        while (mpos != p && n < 2 * FRAME) begin @(negedge clk); n++; end
        if (mpos != p) chk("wait_mpos_timeout", 64'(mpos), 64'(p));
    endtask

    task automatic wait_shown(input int p);
        int n = 0;
        while (shown != p && n < 2 * FRAME) begin @(negedge clk); n++; end
        if (shown != p) chk("wait_shown_timeout", 64'(shown), 64'(p));
    endtask

    task automatic write_cfg(input logic [1:0] a, input logic [9:0] d);
        sync = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        sync = 1'b0; cfg_addr = '0; cfg_data = '0;
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; cfg_addr = '0; cfg_data = '0;
        @(negedge clk);
        checking = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out", {hsync, vsync, blank, frame_start, x, y, base}, {4'b1110, 30'd0});
        chk("reset_pol_idle", {p_hsync, p_vsync}, 2'b00);
        rst = 1'b0;
        @(negedge clk);
        chk("first_frame_start", frame_start, 1'b1);

        // Sync pulse placement, display disabled.
        wait_shown(HA + HF - 1);      chk("hs_before", hsync, 1'b1);
        @(negedge clk);               chk("hs_first", hsync, 1'b0);
        wait_shown(HA + HF + HS - 1); chk("hs_last", hsync, 1'b0);
        @(negedge clk);               chk("hs_after", hsync, 1'b1);
        wait_shown((VA + VF) * HT - 1); chk("vs_before", vsync, 1'b1);
        @(negedge clk);               chk("vs_first", vsync, 1'b0);
        chk("vs_pol_first", p_vsync, 1'b1);
        wait_shown((VA + VF + VS) * HT - 1); chk("vs_last", vsync, 1'b0);
        @(negedge clk);               chk("vs_after", vsync, 1'b1);

        // Enable mid-frame only shows from the next frame.
        wait_mpos(5 * HT + 3);
        write_cfg(2'd3, 10'h3ff);
        wait_shown(6 * HT);           chk("en_deferred", blank, 1'b1);
        wait_shown(0);                chk("en_applied", blank, 1'b0);
        wait_shown(HA - 1);           chk("en_last_px", blank, 1'b0);
        @(negedge clk);               chk("en_hblank", blank, 1'b1);

        // Last write wins; then horizontal wrap of the scrolled coordinate.
        wait_mpos(3 * HT);
        write_cfg(2'd0, 10'd5);
        write_cfg(2'd0, 10'd7);
        wait_shown(0);                chk("xscroll_last_wins", x, 10'd7);
        wait_mpos(4 * HT);
        write_cfg(2'd0, 10'd1020);
        wait_shown(3);                chk("x_pre_wrap", x, 10'd1023);
        @(negedge clk);               chk("x_wrap", x, 10'd0);

        // Write coinciding with the apply cycle is deferred by one frame.
        wait_mpos(FRAME - 1);
        write_cfg(2'd1, 10'd3);
        wait_shown(0);                chk("y_apply_collide", y, 10'd0);
        @(negedge clk);
        wait_shown(0);                chk("y_next_frame", y, 10'd3);

        // Mid-frame reset discards a dirty base.
        wait_mpos(5 * HT + 10);
        write_cfg(2'd2, 10'd9);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out", {hsync, vsync, blank, frame_start, x, y, base}, {4'b1110, 30'd0});
        rst = 1'b0;
        @(negedge clk);               chk("midrst_fs", frame_start, 1'b1);
        wait_shown(FRAME - 1);        chk("midrst_base", base, 10'd0);
        @(negedge clk);               chk("midrst_base_next", base, 10'd0);

        // Random configuration traffic over many frames.
        write_cfg(2'd3, 10'd1);
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                sync = 1'b1;
                cfg_addr = 2'($urandom_range(0, 3));
                cfg_data = 10'($urandom);
                if (cfg_addr == 2'd3 && $urandom_range(0, 3) != 0) cfg_data[0] = 1'b1;
            end else begin
                sync = 1'b0;
            end
            @(negedge clk);
        end
        sync = 1'b0;
        repeat (FRAME + 2) @(negedge clk);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
